// File: rtl/key_command_queue_if.sv
// Command handshake between key_command_queue and game control.
// master = queue side (drives cmd_valid/cmd), slave = consumer side.
interface key_command_queue_if #(
    parameter int CMD_W = 3,
    parameter int DEPTH = 4
);
    logic                     cmd_valid;
    logic [CMD_W-1:0]         cmd;
    logic                     cmd_ready;
    logic [$clog2(DEPTH):0]   queue_count;
    logic                     overflow;

    modport master (
        output cmd_valid, cmd, queue_count, overflow,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd, queue_count, overflow,
        output cmd_ready
    );
endinterface

// File: rtl/key_command_queue.sv
// Key levels -> press/auto-repeat events -> pending bits -> FWFT FIFO.
// KCQ_AUTOREPEAT_EN adds DAS/ARR repeat counters; default is press-only.
module key_command_queue #(
    parameter int NUM_KEYS   = 4,
    parameter int CMD_W      = 3,
    parameter int DEPTH      = 4,
    parameter int DAS_DELAY  = 12_500_000,
    parameter int ARR_PERIOD = 2_500_000,
    parameter int CNT_W      = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_level,
    key_command_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [NUM_KEYS-1:0] key_prev;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] ev;
    logic [NUM_KEYS-1:0] pend;
    logic [NUM_KEYS-1:0] pend_n;
    logic [NUM_KEYS-1:0] clr;
    logic                ovf_hit;
    logic                overflow;

    logic [CMD_W-1:0]    mem [DEPTH];
    logic [PW-1:0]       wptr;
    logic [PW-1:0]       rptr;
    logic [PW:0]         count;
    logic                push;
    logic                pop;
    logic                can_push;
    logic [CMD_W-1:0]    push_cmd;

    assign press = key_level & ~key_prev;

`ifdef KCQ_AUTOREPEAT_EN
    logic [CNT_W-1:0]    rcnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] armed;
    logic [NUM_KEYS-1:0] rpt;

    // armed keeps keys held through reset from repeating
    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= '0;
            for (int i = 0; i < NUM_KEYS; i++) rcnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (press[i]) begin
                    rcnt[i]  <= CNT_W'(DAS_DELAY - 1);
                    armed[i] <= 1'b1;
                end else if (!key_level[i]) begin
                    rcnt[i]  <= '0;
                    armed[i] <= 1'b0;
                end else if (rcnt[i] != '0) begin
                    rcnt[i]  <= rcnt[i] - 1'b1;
                end else if (armed[i]) begin
                    rcnt[i]  <= CNT_W'(ARR_PERIOD - 1);
                end
            end
        end
    end

    always_comb begin
        rpt = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            rpt[i] = key_level[i] & key_prev[i] & armed[i]
                   & (rcnt[i] == '0);
    end

    assign ev = press | rpt;
`else
    assign ev = press;
`endif

    assign pop      = (count != '0) && bus.cmd_ready;
    assign can_push = (count != FULL) || pop;

    // lowest index wins; one push per cycle
    always_comb begin
        clr      = '0;
        push     = 1'b0;
        push_cmd = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (can_push && pend[i] && !push) begin
                push     = 1'b1;
                clr[i]   = 1'b1;
                push_cmd = CMD_W'(i + 1);
            end
        end
    end

    assign pend_n  = (pend & ~clr) | ev;
    assign ovf_hit = |(ev & pend & ~clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            key_prev <= key_level;
            pend     <= '0;
            overflow <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else begin
            key_prev <= key_level;
            pend     <= pend_n;
            if (ovf_hit) overflow <= 1'b1;
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_cmd;
    end

    assign bus.cmd_valid   = (count != '0);
    assign bus.cmd         = (count != '0) ? mem[rptr] : '0;
    assign bus.queue_count = count;
    assign bus.overflow    = overflow;
endmodule
